// File: rtl/reaction_pkg.sv
// Shared constants for the multi-player reaction timer: FSM encoding,
// the "no valid time" sentinel and the 14-bit LFSR definition.
package reaction_pkg;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LIGHTS = 3'd1;
    localparam logic [2:0] HOLD   = 3'd2;
    localparam logic [2:0] TIMING = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;

    localparam int DEF_TIME_W = 14;
    localparam logic [DEF_TIME_W-1:0] SENTINEL = {DEF_TIME_W{1'b1}};

    // Fibonacci taps 14,13,12,2 expressed as bit positions 13,12,11,1.
    localparam int LFSR_W = 14;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 14'b11_1000_0000_0010;
    localparam logic [LFSR_W-1:0] LFSR_SEED = 14'h0001;

    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/lfsr14_free.sv
// Free-running 14-bit LFSR; advances every clock, seeded to 1 on reset.
module lfsr14_free
    import reaction_pkg::*;
(
    input  logic        CLOCK_50,
    input  logic        RESET_N,
    output logic [13:0] q
);

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) q <= LFSR_SEED;
        else          q <= lfsr_step(q);
    end

endmodule

// File: rtl/reaction_timer_mp.sv
// N-player reaction timer: start lights, random hold, race timing with
// false-start and timeout handling, winner arbitration and best-time record.
module reaction_timer_mp
    import reaction_pkg::*;
#(
    parameter int          N_PLAYERS     = 2,
    parameter int          CLK_DIV       = 50000,
    parameter int          N_LIGHTS      = 10,
    parameter int          LIGHT_STEP_MS = 500,
    parameter int          MIN_DELAY_MS  = 200,
    parameter logic [13:0] DELAY_MASK    = 14'h0FFF,
    parameter int          MAX_REACT_MS  = 9999,
    parameter int          TIME_W        = 14
) (
    input  logic                          CLOCK_50,
    input  logic                          RESET_N,
    input  logic                          start,
    input  logic [N_PLAYERS-1:0]          react,
    output logic [N_LIGHTS-1:0]           lights,
    output logic                          busy,
    output logic                          result_valid,
    output logic [N_PLAYERS*TIME_W-1:0]   react_time,
    output logic [N_PLAYERS-1:0]          false_start,
    output logic [N_PLAYERS-1:0]          timed_out,
    output logic [2:0]                    winner,
    output logic                          winner_valid,
    output logic [TIME_W-1:0]             best_time
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [TIME_W-1:0] SENT_T = {TIME_W{1'b1}};

    logic [PW-1:0]         presc_reg;
    logic                  tick;
    logic                  start_q_reg;
    logic                  accept;
    logic [2:0]            state_reg, state_next;
    logic [N_LIGHTS-1:0]   lights_reg, lights_next;
    logic [TIME_W-1:0]     ms_reg, ms_next, ms_inc;
    logic [TIME_W-1:0]     delay_reg, delay_next;
    logic [TIME_W-1:0]     rt_reg [N_PLAYERS];
    logic [TIME_W-1:0]     rt_next [N_PLAYERS];
    logic [N_PLAYERS-1:0]  fs_reg, fs_next, to_reg, to_next, lat_reg, lat_next;
    logic [2:0]            winner_reg;
    logic                  wv_reg;
    logic [TIME_W-1:0]     best_reg;
    logic [13:0]           lfsr_q;
    logic                  enter_done;
    logic                  win_found;
    logic [2:0]            win_idx;
    logic [TIME_W-1:0]     win_time;

    lfsr14_free u_lfsr (
        .CLOCK_50 (CLOCK_50),
        .RESET_N  (RESET_N),
        .q        (lfsr_q)
    );

    assign tick       = (presc_reg == PW'(CLK_DIV - 1));
    assign accept     = start & ~start_q_reg & ~busy;
    assign ms_inc     = ms_reg + TIME_W'(1);
    assign enter_done = (state_next == DONE) && (state_reg != DONE);

    always_comb begin
        state_next  = state_reg;
        lights_next = lights_reg;
        ms_next     = ms_reg;
        delay_next  = delay_reg;
        rt_next     = rt_reg;
        fs_next     = fs_reg;
        to_next     = to_reg;
        lat_next    = lat_reg;
        case (state_reg)
            IDLE, DONE: begin
                if (accept) begin
                    state_next  = LIGHTS;
                    lights_next = '0;
                    ms_next     = '0;
                    fs_next     = '0;
                    to_next     = '0;
                    lat_next    = '0;
                    for (int p = 0; p < N_PLAYERS; p++) rt_next[p] = '0;
                end
            end
            LIGHTS, HOLD: begin
                fs_next = fs_reg | react;
                for (int p = 0; p < N_PLAYERS; p++)
                    if (react[p]) rt_next[p] = SENT_T;
                if (&fs_next) begin
                    state_next  = DONE;
                    lights_next = '0;
                end else if (tick) begin
                    if (state_reg == LIGHTS) begin
                        if (ms_inc == TIME_W'(LIGHT_STEP_MS)) begin
                            ms_next     = '0;
                            lights_next = (lights_reg << 1) | N_LIGHTS'(1);
                            // The random part is sampled the moment the last light comes on.
                            if (&lights_next) begin
                                state_next = HOLD;
                                delay_next = TIME_W'(MIN_DELAY_MS) + TIME_W'(lfsr_q & DELAY_MASK);
                            end
                        end else begin
                            ms_next = ms_inc;
                        end
                    end else if (delay_reg <= TIME_W'(1)) begin
                        state_next  = TIMING;
                        lights_next = '0;
                        ms_next     = '0;
                    end else begin
                        delay_next = delay_reg - TIME_W'(1);
                    end
                end
            end
            TIMING: begin
                for (int p = 0; p < N_PLAYERS; p++) begin
                    if (react[p] && !lat_reg[p] && !fs_reg[p]) begin
                        lat_next[p] = 1'b1;
                        rt_next[p]  = ms_reg;
                    end
                end
                if (tick) ms_next = ms_inc;
                if (&(lat_next | fs_reg)) begin
                    state_next = DONE;
                end else if (tick && ms_inc == TIME_W'(MAX_REACT_MS)) begin
                    state_next = DONE;
                    for (int p = 0; p < N_PLAYERS; p++) begin
                        if (!lat_next[p] && !fs_reg[p]) begin
                            rt_next[p] = SENT_T;
                            to_next[p] = 1'b1;
                        end
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Strict less-than keeps the lowest index on a tie.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_time  = SENT_T;
        for (int p = 0; p < N_PLAYERS; p++) begin
            if (lat_next[p] && rt_next[p] < win_time) begin
                win_found = 1'b1;
                win_idx   = 3'(p);
                win_time  = rt_next[p];
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            presc_reg   <= '0;
            start_q_reg <= 1'b0;
            state_reg   <= IDLE;
            lights_reg  <= '0;
            ms_reg      <= '0;
            delay_reg   <= '0;
            fs_reg      <= '0;
            to_reg      <= '0;
            lat_reg     <= '0;
            winner_reg  <= '0;
            wv_reg      <= 1'b0;
            best_reg    <= SENT_T;
            for (int p = 0; p < N_PLAYERS; p++) rt_reg[p] <= '0;
        end else begin
            presc_reg   <= tick ? '0 : presc_reg + PW'(1);
            start_q_reg <= start;
            state_reg   <= state_next;
            lights_reg  <= lights_next;
            ms_reg      <= ms_next;
            delay_reg   <= delay_next;
            fs_reg      <= fs_next;
            to_reg      <= to_next;
            lat_reg     <= lat_next;
            rt_reg      <= rt_next;
            if (enter_done) begin
                winner_reg <= win_idx;
                wv_reg     <= win_found;
                if (win_found && win_time < best_reg) best_reg <= win_time;
            end else if (accept) begin
                winner_reg <= '0;
                wv_reg     <= 1'b0;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < N_PLAYERS; gi++) begin : g_pack
            assign react_time[gi*TIME_W +: TIME_W] = rt_reg[gi];
        end
    endgenerate

    assign lights       = lights_reg;
    assign busy         = (state_reg == LIGHTS) || (state_reg == HOLD) || (state_reg == TIMING);
    assign result_valid = (state_reg == DONE);
    assign false_start  = fs_reg;
    assign timed_out    = to_reg;
    assign winner       = winner_reg;
    assign winner_valid = wv_reg;
    assign best_time    = best_reg;

endmodule
